ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Iterative controller for the RV32M extension, sitting beside the EX-stage ALU.
- When EX holds a MUL/DIV/REM instruction, it sequences a 32-iteration shift-add multiplier / restoring divider.
- It stalls IF/ID/EX while the operation runs, then presents the 32-bit result for the EX→MEM alu_result mux.
- One operation is in flight at a time; pipeline flushes abort it.

Parameters:
- XLEN, 32, operand/result width (core DATA_WIDTH; only 32 is verified).
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start_i  input  1  EX holds a valid M-extension instruction (held high while stalled).
- funct3_i  input  3  instruction[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand1_i  input  XLEN  rs1 value (post-forwarding).
- operand2_i  input  XLEN  rs2 value (post-forwarding).
- flush_i  input  1  EX-stage flush (branch/jump redirect).
- ext_stall_i  input  1  downstream stall (e.g. MEM); pipeline cannot advance this cycle.
- stall_o  output  1  freeze PC, IF/ID and ID/EX registers.
- done_o  output  1  result_o valid for the instruction in EX.
- result_o  output  XLEN  selected product half, quotient or remainder.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0, internal accumulators=0, result_o=0, done_o=0. stall_o is forced to 0 while rst is high.
- State IDLE:
  - stall_o = start_i & ~flush_i.
  - On start_i & ~flush_i, latch funct3 and the operands.
  - Signed ops (MULH, MULHSU rs1 only, DIV, REM): latch absolute values and record the result sign.
  - Next state is CALC with counter=0.
- Special cases (detected in IDLE, bypass CALC, go straight to DONE with result registered):
  - DIV/DIVU with divisor 0: quotient = all ones (0xFFFFFFFF).
  - REM/REMU with divisor 0: remainder = dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000. REM of the same pair: 0.
- State CALC:
  - stall_o=1.
  - One iteration per cycle: multiply = conditional add + right shift of the 64-bit product; divide = restoring shift-subtract producing one quotient bit.
  - Counter increments each cycle. After iteration XLEN-1 (counter==31), apply sign correction, register result_o, go to DONE.
- State DONE:
  - done_o=1, stall_o=0, result_o stable.
  - If ext_stall_i=0, return to IDLE next cycle (the instruction leaves EX).
  - If ext_stall_i=1, stay in DONE holding result_o; start_i being high here must NOT restart the operation.
- Latency:
  - Normal op: start seen in cycle 0, CALC cycles 1..32, done_o in cycle 33, so 33 stall cycles.
  - Special case: done_o in cycle 1, one stall cycle.
- Result selection:
  - MUL = product[31:0].
  - MULH/MULHSU/MULHU = product[63:32] after 64-bit two's-complement correction.
  - DIV/DIVU = quotient.
  - REM/REMU = remainder; the remainder takes the dividend's sign.
- Flush:
  - flush_i in any state sends the FSM to IDLE next cycle. done_o stays low and result_o keeps its old value.
  - flush_i has priority over start_i in the same cycle.
  - A new start may be accepted in the cycle after the flush.
- Back-to-back: a new start_i is accepted only from IDLE, so consecutive M instructions each take full latency. There is no forwarding of the previous result inside this block.
- Reset asserted mid-CALC: immediate return to IDLE with all outputs at reset values. No done_o pulse is produced for the aborted op.
- Operands are sampled only in IDLE; changes on operand1_i/operand2_i during CALC are ignored.

Test Plan:
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), funct3=000 → stall_o high 33 cycles, done_o at cycle 33, result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20 / 3 → 0xFFFFFFFA. REM −20 / 3 → 0xFFFFFFFE. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU x/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done_o at cycle 1. DIV 0x80000000 / −1 → 0x80000000 and REM → 0, both in 1 cycle.
- Start DIV, assert flush_i at cycle 10 → IDLE at cycle 11, stall_o low, no done_o. Restart at cycle 12 completes normally 33 cycles later.
- Hold ext_stall_i=1 for 3 cycles after done_o → DONE held with result stable and no restart despite start_i=1. Assert rst mid-CALC → outputs at reset values immediately.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// RV32M iterative multiply/divide unit beside the EX-stage ALU; 32-step shift-add / restoring divide.
// Latency: 33 stall cycles for a normal op (done_o in cycle 33), 1 for divide-by-zero / overflow.
// Backpressure: stall_o freezes IF/ID/EX while busy; ext_stall_i holds the result in DONE.
//
// Ports:
//   clk, rst            core clock (rising edge), asynchronous active-high reset
//   start_i, funct3_i   EX holds an M instruction (held high while stalled) and its funct3
//   operand1_i/2_i      rs1/rs2 after forwarding, sampled only when an op is accepted in IDLE
//   flush_i             EX flush, aborts any op and returns to IDLE
//   ext_stall_i         downstream stall, keeps the finished result presented in DONE
//   stall_o, done_o     pipeline freeze request, result valid strobe
//   result_o            product half, quotient or remainder
module ex_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic            flush_i,
    input  logic            ext_stall_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          funct3_q;
    logic                neg_q;
    // Shared accumulator: multiply keeps {partial product, remaining multiplier bits};
    // divide keeps {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*XLEN-1:0]   acc_q;
    // Multiplicand (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0]     opb_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic                is_div;
    logic                is_rem;
    logic                signed1, signed2;
    logic                s1, s2;
    logic                neg_d;
    logic [XLEN-1:0]     op1_abs, op2_abs;
    logic                div_by_zero, div_ovf, is_special;
    logic [XLEN-1:0]     special_res;

    always_comb begin
        is_div  = funct3_i[2];
        is_rem  = funct3_i[2] & funct3_i[1];
        // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM.
        signed1 = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                  (funct3_i == 3'b100) | (funct3_i == 3'b110);
        signed2 = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
        s1      = signed1 & operand1_i[XLEN-1];
        s2      = signed2 & operand2_i[XLEN-1];
        op1_abs = s1 ? -operand1_i : operand1_i;
        op2_abs = s2 ? -operand2_i : operand2_i;
        // Remainder follows the dividend's sign; everything else follows the product/quotient sign.
        neg_d   = is_rem ? s1 : (s1 ^ s2);

        div_by_zero = is_div & (operand2_i == '0);
        div_ovf     = is_div & ~funct3_i[0] &
                      (operand1_i == INT_MIN) & (operand2_i == ALL_ONES);
        is_special  = div_by_zero | div_ovf;

        special_res = '0;
        if (div_by_zero) begin
            special_res = funct3_i[1] ? operand1_i : ALL_ONES;
        end else if (div_ovf) begin
            special_res = funct3_i[1] ? '0 : INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       div_shift, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   div_nxt;
    logic [2*XLEN-1:0]   acc_nxt;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo, rem;
    logic [XLEN-1:0]     final_res;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier LSB is set, then shift right.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: shift in the next dividend bit, keep the difference if it did not borrow.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[XLEN];
        div_nxt   = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

        acc_nxt = funct3_q[2] ? div_nxt : mul_nxt;

        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo      = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem      = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

        case (funct3_q)
            3'b000:         final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: final_res = quo;
            default:        final_res = rem;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = start_i & ~flush_i;
                if (start_i && !flush_i) begin
                    accept    = 1'b1;
                    state_nxt = is_special ? DONE : CALC;
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                // start_i is still high here for the same instruction; never re-accept it.
                if (flush_i || !ext_stall_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            stall_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            funct3_q <= funct3_i;
            neg_q    <= neg_d;
            cnt_q    <= '0;
            if (is_special) begin
                result_q <= special_res;
            end else if (is_div) begin
                acc_q <= {{XLEN{1'b0}}, op1_abs};
                opb_q <= op2_abs;
            end else begin
                acc_q <= {{XLEN{1'b0}}, op2_abs};
                opb_q <= op1_abs;
            end
        end else if (state_q == CALC && !flush_i) begin
            acc_q <= acc_nxt;
            if (cnt_q == LAST_ITER) begin
                cnt_q    <= '0;
                result_q <= final_res;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (flush_i) begin
            cnt_q <= '0;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed vectors, random ops against an arithmetic model,
// and hand sequences for flush, held-done under downstream stall, and reset during an operation.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] operand1_i;
    logic [31:0] operand2_i;
    logic        flush_i;
    logic        ext_stall_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = 32'h0;

    ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .flush_i    (flush_i),
        .ext_stall_i(ext_stall_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model from the RV32M definitions using 64-bit host arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb;             return p[31:0];  end
            3'd1: begin p = sa * sb;             return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);   return p[63:32]; end
            3'd3: begin p = ua * ub;             return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; p = q; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; p = q; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op starting in the next cycle, scramble operands while it runs, optionally hold
    // the result with ext_stall_i for 'hold' cycles, then let the instruction leave EX.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int hold, input string nm);
        int cyc    = 0;
        int stalls = 0;
        bit seen   = 0;
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = f3; operand1_i = a; operand2_i = b;
        flush_i = 1'b0; ext_stall_i = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1;
            end else begin
                if (stall_o) stalls++;
                @(posedge clk); #1;
                cyc++;
                if (cyc == 1) begin
                    operand1_i = $urandom;
                    operand2_i = $urandom;
                end
            end
        end
        chk({nm, " done seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        chk({nm, " result"}, result_o, exp);
        chk({nm, " stall at done"}, 32'(stall_o), 32'd0);
        last_res = exp;
        if (hold > 0) ext_stall_i = 1'b1;
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            if (h == hold) ext_stall_i = 1'b0;
            @(negedge clk);
            chk({nm, " held done"}, 32'(done_o), 32'd1);
            chk({nm, " held result"}, result_o, exp);
            chk({nm, " held stall"}, 32'(stall_o), 32'd0);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk({nm, " done drops"}, 32'(done_o), 32'd0);
        chk({nm, " idle stall"}, 32'(stall_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        bit          saw_done;

        tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33};
        tbl[5]  = '{3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33};
        tbl[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        tbl[7]  = '{3'd5, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1};
        tbl[8]  = '{3'd6, 32'd5,         32'h0,         32'd5,         1};
        tbl[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        tbl[11] = '{3'd4, 32'hFFFF_FFEC, 32'h0,         32'hFFFF_FFFF, 1};
        tbl[12] = '{3'd0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33};
        tbl[13] = '{3'd7, 32'd100,       32'd7,         32'd2,         33};

        // Reset state, with start_i already high to show stall_o is forced low.
        rst = 1'b1; start_i = 1'b1; funct3_i = 3'd0; operand1_i = 32'd3; operand2_i = 32'd4;
        flush_i = 1'b0; ext_stall_i = 1'b0;
        #12;
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 40; n++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = rnd_op();
            rb  = rnd_op();
            do_op(rf3, ra, rb, ref_result(rf3, ra, rb), ref_lat(rf3, ra, rb), 0,
                  $sformatf("rnd%0d f3=%0d a=%h b=%h", n, rf3, ra, rb));
        end

        // Flush during a DIV at cycle 10, idle at 11, restart at 12.
        saw_done = 0;
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = 3'd4; operand1_i = 32'hFFFF_FFEC; operand2_i = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_o) saw_done = 1;
            @(posedge clk); #1;
            if (c == 10) flush_i = 1'b1;
        end
        @(negedge clk);
        if (done_o) saw_done = 1;
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        if (done_o) saw_done = 1;
        chk("flush no done", 32'(saw_done), 32'd0);
        chk("flush idle stall", 32'(stall_o), 32'd0);
        chk("flush result kept", result_o, last_res);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "after flush");

        // Downstream stall holds DONE for 3 cycles with start_i still high.
        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 3, "ext stall");

        // Reset in the middle of CALC.
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = 3'd3; operand1_i = 32'hFFFF_FFFF; operand2_i = 32'hFFFF_FFFF;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid reset stall", 32'(stall_o), 32'd0);
        chk("mid reset done", 32'(done_o), 32'd0);
        chk("mid reset result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || stall_o) saw_done = 1;
        end
        chk("no done after abort", 32'(saw_done), 32'd0);
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
